// File: rtl/stg5mo.sv
`default_nettype none
// ============================================================================
// Module      : stg5mo
// Description : Memory-operation pipeline stage. Sits directly downstream of
//               the memory-address stage and completes LD/ST instructions
//               against the bank that stage already selected (iw_mem_mp),
//               using a registered req / one-cycle ack handshake. The pipe is
//               stalled (ow_stall, combinational) while a request is pending.
//               One registered bundle per cycle goes to writeback: the
//               instruction itself when it completes (load data replaces the
//               result), otherwise a bubble (NOP, no register writes).
// Ports       : iw_clk/iw_rst         clock, synchronous active-high reset
//               iw_pc..iw_result      upstream pipeline latch + bank select
//               ow_mem_*/iw_mem_*     memory request / acknowledge channel
//               ow_stall              hold-upstream indication
//               ow_fault              one-cycle pulse on request timeout
//               ow_pc..ow_result      registered bundle to writeback
// Options     : `define MEM_TIMEOUT_EN to abort a request after TIMEOUT WAIT
//               cycles without ack (instruction dropped, ow_fault pulsed).
//               Without it the stage waits indefinitely and ow_fault is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module stg5mo #(
    parameter int HBIT_ADDR   = 15,
    parameter int HBIT_DATA   = 15,
    parameter int HBIT_OPC    = 5,
    parameter int HBIT_TGT_GP = 3,
    parameter int HBIT_TGT_SR = 1,
    parameter int TIMEOUT     = 16,
    parameter logic [HBIT_OPC:0] OPC_NOP     = '0,
    parameter logic [HBIT_OPC:0] OPC_R_LD    = 6'h10,
    parameter logic [HBIT_OPC:0] OPC_R_ST    = 6'h11,
    parameter logic [HBIT_OPC:0] OPC_I_STi   = 6'h12,
    parameter logic [HBIT_OPC:0] OPC_IS_STis = 6'h13
) (
    input  logic                   iw_clk,
    input  logic                   iw_rst,
    input  logic [HBIT_ADDR:0]     iw_pc,
    input  logic [HBIT_DATA:0]     iw_instr,
    input  logic [HBIT_OPC:0]      iw_opc,
    input  logic [HBIT_TGT_GP:0]   iw_tgt_gp,
    input  logic                   iw_tgt_gp_we,
    input  logic [HBIT_TGT_SR:0]   iw_tgt_sr,
    input  logic                   iw_tgt_sr_we,
    input  logic                   iw_mem_mp,
    input  logic [HBIT_DATA:0]     iw_result,
    output logic                   ow_mem_req,
    output logic                   ow_mem_we,
    output logic                   ow_mem_bank,
    output logic [HBIT_DATA:0]     ow_mem_wdata,
    input  logic                   iw_mem_ack,
    input  logic [HBIT_DATA:0]     iw_mem_rdata,
    output logic                   ow_stall,
    output logic                   ow_fault,
    output logic [HBIT_ADDR:0]     ow_pc,
    output logic [HBIT_DATA:0]     ow_instr,
    output logic [HBIT_OPC:0]      ow_opc,
    output logic [HBIT_TGT_GP:0]   ow_tgt_gp,
    output logic                   ow_tgt_gp_we,
    output logic [HBIT_TGT_SR:0]   ow_tgt_sr,
    output logic                   ow_tgt_sr_we,
    output logic [HBIT_DATA:0]     ow_result
);

    // Elaboration-time range guard for the timeout threshold.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("stg5mo: TIMEOUT must be in 1..255");
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state;
    logic   is_load;
    logic   is_mem;
    logic   take_bundle;
    logic   timeout_hit;

    assign is_load = (iw_opc == OPC_R_LD);
    assign is_mem  = is_load || (iw_opc == OPC_R_ST) ||
                     (iw_opc == OPC_I_STi) || (iw_opc == OPC_IS_STis);

`ifdef MEM_TIMEOUT_EN
    // Counter holds the number of completed WAIT cycles without ack, so the
    // TIMEOUT-th WAIT cycle is the one that sees TIMEOUT-1 here.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;

    assign timeout_hit = (state == S_WAIT) && !iw_mem_ack && (wait_cnt >= TO_LAST);

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            wait_cnt <= '0;
            ow_fault <= 1'b0;
        end else begin
            ow_fault <= timeout_hit;
            // Held at zero in IDLE, so it is clear on entry to WAIT.
            if (state == S_IDLE) begin
                wait_cnt <= '0;
            end else if (!iw_mem_ack && (wait_cnt != 8'hFF)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign ow_fault    = 1'b0;
`endif

    // Instruction leaves the stage: non-mem op in IDLE, or ack in WAIT.
    // A timeout also releases upstream but forwards a bubble instead.
    assign take_bundle = (state == S_IDLE) ? !is_mem : iw_mem_ack;
    assign ow_stall    = (state == S_IDLE) ? is_mem : !(iw_mem_ack || timeout_hit);

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state        <= S_IDLE;
            ow_mem_req   <= 1'b0;
            ow_mem_we    <= 1'b0;
            ow_mem_bank  <= 1'b0;
            ow_mem_wdata <= '0;
            ow_pc        <= '0;
            ow_instr     <= '0;
            ow_opc       <= '0;
            ow_tgt_gp    <= '0;
            ow_tgt_gp_we <= 1'b0;
            ow_tgt_sr    <= '0;
            ow_tgt_sr_we <= 1'b0;
            ow_result    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_mem) begin
                        state        <= S_WAIT;
                        ow_mem_req   <= 1'b1;
                        ow_mem_we    <= !is_load;
                        ow_mem_bank  <= iw_mem_mp;
                        ow_mem_wdata <= iw_result;
                    end
                end
                S_WAIT: begin
                    if (iw_mem_ack || timeout_hit) begin
                        state      <= S_IDLE;
                        ow_mem_req <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    ow_mem_req <= 1'b0;
                end
            endcase

            if (take_bundle) begin
                // Upstream holds its latch during the stall, so the inputs
                // still describe the instruction being completed.
                ow_pc        <= iw_pc;
                ow_instr     <= iw_instr;
                ow_opc       <= iw_opc;
                ow_tgt_gp    <= iw_tgt_gp;
                ow_tgt_gp_we <= iw_tgt_gp_we;
                ow_tgt_sr    <= iw_tgt_sr;
                ow_tgt_sr_we <= iw_tgt_sr_we;
                ow_result    <= ((state == S_WAIT) && is_load) ? iw_mem_rdata : iw_result;
            end else begin
                ow_pc        <= '0;
                ow_instr     <= '0;
                ow_opc       <= OPC_NOP;
                ow_tgt_gp    <= '0;
                ow_tgt_gp_we <= 1'b0;
                ow_tgt_sr    <= '0;
                ow_tgt_sr_we <= 1'b0;
                ow_result    <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stg5mo.sv
`default_nettype none
// ============================================================================
// Module      : tb_stg5mo
// Description : Self-checking bench for stg5mo. Expected writeback bundles are
//               pushed to a queue when an instruction is driven and popped at
//               the following cycle's mid-point against the DUT outputs.
//               Timeout cases run only when MEM_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stg5mo;

    localparam logic [5:0] OPC_NOP     = 6'h00;
    localparam logic [5:0] OPC_R_ADD   = 6'h01;
    localparam logic [5:0] OPC_R_SUB   = 6'h02;
    localparam logic [5:0] OPC_I_ORi   = 6'h05;
    localparam logic [5:0] OPC_R_LD    = 6'h10;
    localparam logic [5:0] OPC_R_ST    = 6'h11;
    localparam logic [5:0] OPC_I_STi   = 6'h12;
    localparam logic [5:0] OPC_IS_STis = 6'h13;
    localparam int         TIMEOUT     = 4;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [5:0]  opc;
        logic [3:0]  gp;
        logic        gp_we;
        logic [1:0]  sr;
        logic        sr_we;
        logic [15:0] result;
    } bundle_t;

    typedef struct packed {
        bundle_t in;
        bundle_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc, instr, result, mem_rdata, mem_wdata, out_pc, out_instr, out_result;
    logic [5:0]  opc, out_opc;
    logic [3:0]  tgt_gp, out_tgt_gp;
    logic [1:0]  tgt_sr, out_tgt_sr;
    logic        tgt_gp_we, tgt_sr_we, mem_mp, mem_ack;
    logic        mem_req, mem_we, mem_bank, stall, fault, out_tgt_gp_we, out_tgt_sr_we;

    bundle_t     exp_q[$];
    bundle_t     bubble;
    bit          cur_req, cur_fault;
    int          total, bad;

    stg5mo #(.TIMEOUT(TIMEOUT)) dut (
        .iw_clk(clk), .iw_rst(rst),
        .iw_pc(pc), .iw_instr(instr), .iw_opc(opc),
        .iw_tgt_gp(tgt_gp), .iw_tgt_gp_we(tgt_gp_we),
        .iw_tgt_sr(tgt_sr), .iw_tgt_sr_we(tgt_sr_we),
        .iw_mem_mp(mem_mp), .iw_result(result),
        .ow_mem_req(mem_req), .ow_mem_we(mem_we), .ow_mem_bank(mem_bank),
        .ow_mem_wdata(mem_wdata), .iw_mem_ack(mem_ack), .iw_mem_rdata(mem_rdata),
        .ow_stall(stall), .ow_fault(fault),
        .ow_pc(out_pc), .ow_instr(out_instr), .ow_opc(out_opc),
        .ow_tgt_gp(out_tgt_gp), .ow_tgt_gp_we(out_tgt_gp_we),
        .ow_tgt_sr(out_tgt_sr), .ow_tgt_sr_we(out_tgt_sr_we),
        .ow_result(out_result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic bundle_t mk(input logic [15:0] p, input logic [15:0] ins,
                                   input logic [5:0] o, input logic [3:0] g, input logic gwe,
                                   input logic [1:0] s, input logic swe, input logic [15:0] r);
        bundle_t b;
        b.pc = p; b.instr = ins; b.opc = o; b.gp = g; b.gp_we = gwe;
        b.sr = s; b.sr_we = swe; b.result = r;
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_bundle(input bundle_t e);
        chk("out_pc",        out_pc,        e.pc);
        chk("out_instr",     out_instr,     e.instr);
        chk("out_opc",       out_opc,       e.opc);
        chk("out_tgt_gp",    out_tgt_gp,    e.gp);
        chk("out_tgt_gp_we", out_tgt_gp_we, e.gp_we);
        chk("out_tgt_sr",    out_tgt_sr,    e.sr);
        chk("out_tgt_sr_we", out_tgt_sr_we, e.sr_we);
        chk("out_result",    out_result,    e.result);
    endtask

    task automatic drive(input bundle_t b);
        pc = b.pc; instr = b.instr; opc = b.opc; tgt_gp = b.gp; tgt_gp_we = b.gp_we;
        tgt_sr = b.sr; tgt_sr_we = b.sr_we; result = b.result;
    endtask

    // One clock: check this cycle's stall and the registered outputs left by
    // the previous edge, then record what the coming edge must produce.
    task automatic tick(input bit exp_stall, input bundle_t nxt, input bit nxt_req, input bit nxt_fault);
        bundle_t e;
        @(negedge clk);
        chk("stall", stall, exp_stall);
        chk("mem_req", mem_req, cur_req);
        chk("fault", fault, cur_fault);
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: actual=empty required=entry");
        end else begin
            e = exp_q.pop_front();
            chk_bundle(e);
        end
        exp_q.push_back(nxt);
        cur_req   = nxt_req;
        cur_fault = nxt_fault;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back('0);
        cur_req   = 1'b0;
        cur_fault = 1'b0;
    endtask

    // Memory op: IDLE cycle, nwait WAIT cycles without ack, then either an
    // ack cycle or (timeout=1) the aborting WAIT cycle.
    task automatic mem_op(input bundle_t in, input bit mp, input logic [15:0] rdata,
                          input int nwait, input bit timeout);
        bundle_t done;
        bit      ld;
        ld = (in.opc == OPC_R_LD);
        drive(in);
        mem_mp = mp;
        tick(1'b1, bubble, 1'b1, 1'b0);
        chk("mem_we",    mem_we,    !ld);
        chk("mem_bank",  mem_bank,  mp);
        chk("mem_wdata", mem_wdata, in.result);
        for (int i = 0; i < nwait; i++) begin
            tick(1'b1, bubble, 1'b1, 1'b0);
            chk("mem_bank_hold",  mem_bank,  mp);
            chk("mem_wdata_hold", mem_wdata, in.result);
        end
        if (timeout) begin
            tick(1'b0, bubble, 1'b0, 1'b1);
        end else begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
            done = in;
            if (ld) done.result = rdata;
            tick(1'b0, done, 1'b0, 1'b0);
            mem_ack   = 1'b0;
            mem_rdata = 16'h5A5A;
        end
    endtask

    vec_t    vecs[5];
    bundle_t ld_a, st_b, sti_c, ld_d, nm;

    initial begin
        total = 0; bad = 0;
        bubble = mk(16'h0, 16'h0, OPC_NOP, 4'h0, 1'b0, 2'h0, 1'b0, 16'h0);
        drive(bubble);
        mem_mp = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h5A5A; rst = 1'b1;
        cur_req = 1'b0; cur_fault = 1'b0;

        vecs[0].in = mk(16'h0100, 16'h1101, OPC_R_ADD, 4'h1, 1'b1, 2'h0, 1'b0, 16'h1234);
        vecs[1].in = mk(16'h0102, 16'h2202, OPC_R_SUB, 4'h7, 1'b1, 2'h2, 1'b1, 16'hFFFE);
        vecs[2].in = mk(16'h0104, 16'h5503, OPC_I_ORi, 4'hF, 1'b0, 2'h1, 1'b1, 16'h8001);
        vecs[3].in = mk(16'hFFFE, 16'hFFFF, OPC_NOP,   4'h0, 1'b0, 2'h3, 1'b0, 16'h0000);
        vecs[4].in = mk(16'h0108, 16'h1104, OPC_R_ADD, 4'h3, 1'b1, 2'h0, 1'b0, 16'hA5A5);
        for (int i = 0; i < 5; i++) vecs[i].exp = vecs[i].in;

        do_reset();

        // Non-memory ops flow through in one cycle without stalling.
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].in);
            tick(1'b0, vecs[i].exp, 1'b0, 1'b0);
        end

        // LD from bank 1, ack after 3 WAIT cycles.
        ld_a = mk(16'h0200, 16'h3001, OPC_R_LD, 4'h2, 1'b1, 2'h0, 1'b0, 16'h0040);
        mem_op(ld_a, 1'b1, 16'hBEEF, 3, 1'b0);

        // ST to bank 0, ack on the first WAIT cycle.
        st_b = mk(16'h0202, 16'h3102, OPC_R_ST, 4'h0, 1'b0, 2'h0, 1'b0, 16'h00AA);
        mem_op(st_b, 1'b0, 16'h7777, 0, 1'b0);

        // Back-to-back mem ops: req must drop for the IDLE cycle in between.
        sti_c = mk(16'h0204, 16'h3203, OPC_I_STi, 4'h0, 1'b0, 2'h1, 1'b1, 16'h1357);
        mem_op(sti_c, 1'b1, 16'h0000, 1, 1'b0);
        ld_d = mk(16'h0206, 16'h3304, OPC_R_LD, 4'h9, 1'b1, 2'h0, 1'b0, 16'h2468);
        mem_op(ld_d, 1'b0, 16'h0F0F, 2, 1'b0);

        // Stray ack in IDLE: must not replace the result.
        nm = mk(16'h0300, 16'h1105, OPC_R_ADD, 4'h4, 1'b1, 2'h0, 1'b0, 16'h4321);
        drive(nm);
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        tick(1'b0, nm, 1'b0, 1'b0);
        mem_ack = 1'b0; mem_rdata = 16'h5A5A;

        // Reset on the 2nd WAIT cycle together with ack: ack is lost.
        drive(ld_a);
        mem_mp = 1'b1;
        tick(1'b1, bubble, 1'b1, 1'b0);
        tick(1'b1, bubble, 1'b1, 1'b0);
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hC0DE;
        tick(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(nm);
        tick(1'b0, nm, 1'b0, 1'b0);
        mem_ack = 1'b0; mem_rdata = 16'h5A5A;
        // Fresh mem op after reset must start from IDLE with req low.
        mem_op(st_b, 1'b1, 16'h0000, 0, 1'b0);

`ifdef MEM_TIMEOUT_EN
        // No ack: abort on the TIMEOUT-th WAIT cycle, fault pulse, bubble.
        mem_op(ld_a, 1'b0, 16'h0000, TIMEOUT - 1, 1'b1);
        drive(vecs[1].in);
        tick(1'b0, vecs[1].exp, 1'b0, 1'b0);
        // Ack on the timeout cycle wins.
        mem_op(ld_d, 1'b1, 16'h6B6B, TIMEOUT - 1, 1'b0);
        drive(vecs[0].in);
        tick(1'b0, vecs[0].exp, 1'b0, 1'b0);
`endif

        drive(bubble);
        tick(1'b0, bubble, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
